// File: rtl/coverage_accumulator_if.sv
// Bus interface for coverage_accumulator.
//   master : hit producer / round controller (drives clear, hit_valid, hit)
//   slave  : the accumulator (drives cov_sum, busy, saturated)
// Optional feature macro: COV_NEW_PULSE_EN adds cov_new / cov_new_cnt.
interface coverage_accumulator_if #(
  parameter int N_POINTS = 1024,
  parameter int SUM_W    = 30
);
  logic                clear;
  logic                hit_valid;
  logic [N_POINTS-1:0] hit;
  logic [SUM_W-1:0]    cov_sum;
  logic                busy;
  logic                saturated;
`ifdef COV_NEW_PULSE_EN
  logic                      cov_new;
  logic [$clog2(N_POINTS):0] cov_new_cnt;

  modport master (output clear, hit_valid, hit,
                  input  cov_sum, busy, saturated, cov_new, cov_new_cnt);
  modport slave  (input  clear, hit_valid, hit,
                  output cov_sum, busy, saturated, cov_new, cov_new_cnt);
`else
  modport master (output clear, hit_valid, hit,
                  input  cov_sum, busy, saturated);
  modport slave  (input  clear, hit_valid, hit,
                  output cov_sum, busy, saturated);
`endif
endinterface

// File: rtl/coverage_accumulator.sv
// coverage_accumulator: keeps a bitmap of coverage points seen since the last
// clear and adds every newly seen point to a saturating running total.
// Three-stage pipeline: S1 registers the hit vector, S2 masks it against the
// bitmap and registers per-group popcounts, S3 sums groups into cov_sum.
// Ports:
//   clock, reset : core clock, asynchronous active-high reset
//   bus (slave)  : clear, hit_valid, hit in; cov_sum, busy, saturated out
// Optional feature macro: COV_NEW_PULSE_EN -> cov_new one-cycle pulse and
// cov_new_cnt (number of new points) aligned with each non-zero S3 update.
module coverage_accumulator #(
  parameter int N_POINTS = 1024,
  parameter int GROUP    = 64,
  parameter int SUM_W    = 30
) (
  input logic                    clock,
  input logic                    reset,
  coverage_accumulator_if.slave  bus
);
  localparam int N_GRP = N_POINTS / GROUP;
  localparam int CNT_W = $clog2(GROUP) + 1;
  localparam int TOT_W = $clog2(N_POINTS) + 1;
  // Adder is wide enough for both operands plus carry, so the compare is exact.
  localparam int ADD_W = ((SUM_W > TOT_W) ? SUM_W : TOT_W) + 1;
  localparam logic [ADD_W-1:0] SAT_MAX = {{(ADD_W-SUM_W){1'b0}}, {SUM_W{1'b1}}};

  logic                           s1_v_q, s1_v_d;
  logic [N_POINTS-1:0]            s1_hit_q, s1_hit_d;
  logic [N_POINTS-1:0]            seen_q, seen_d;
  logic                           s2_v_q, s2_v_d;
  logic [N_GRP-1:0][CNT_W-1:0]    grp_cnt_q, grp_cnt_d;
  logic [SUM_W-1:0]               cov_sum_q, cov_sum_d;
  logic                           saturated_q, saturated_d;

  logic [N_POINTS-1:0]            new_bits;
  logic [TOT_W-1:0]               total;
  logic [ADD_W-1:0]               sum_wide;

  always_comb begin
    s1_v_d   = bus.hit_valid & ~bus.clear;
    s1_hit_d = s1_v_d ? bus.hit : '0;

    // Bitmap update and masking happen on the same edge, so a point repeated
    // in the next vector already sees itself as old.
    new_bits = s1_v_q ? (s1_hit_q & ~seen_q) : '0;
    seen_d   = s1_v_q ? (seen_q | s1_hit_q) : seen_q;
    s2_v_d   = s1_v_q;
    for (int g = 0; g < N_GRP; g++) begin
      grp_cnt_d[g] = '0;
      for (int i = 0; i < GROUP; i++) begin
        grp_cnt_d[g] = grp_cnt_d[g] + CNT_W'(new_bits[g*GROUP + i]);
      end
    end

    total = '0;
    for (int g = 0; g < N_GRP; g++) begin
      total = total + TOT_W'(grp_cnt_q[g]);
    end
    sum_wide    = ADD_W'(cov_sum_q) + ADD_W'(total);
    cov_sum_d   = cov_sum_q;
    saturated_d = saturated_q;
    if (s2_v_q) begin
      if (sum_wide >= SAT_MAX) begin
        cov_sum_d   = '1;
        saturated_d = 1'b1;
      end else begin
        cov_sum_d = sum_wide[SUM_W-1:0];
      end
    end

    // Round restart discards everything in flight, including this cycle's vector.
    if (bus.clear) begin
      seen_d      = '0;
      s2_v_d      = 1'b0;
      grp_cnt_d   = '0;
      cov_sum_d   = '0;
      saturated_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_v_q      <= 1'b0;
      s1_hit_q    <= '0;
      seen_q      <= '0;
      s2_v_q      <= 1'b0;
      grp_cnt_q   <= '0;
      cov_sum_q   <= '0;
      saturated_q <= 1'b0;
    end else begin
      s1_v_q      <= s1_v_d;
      s1_hit_q    <= s1_hit_d;
      seen_q      <= seen_d;
      s2_v_q      <= s2_v_d;
      grp_cnt_q   <= grp_cnt_d;
      cov_sum_q   <= cov_sum_d;
      saturated_q <= saturated_d;
    end
  end

  assign bus.cov_sum   = cov_sum_q;
  assign bus.saturated = saturated_q;
  assign bus.busy      = s1_v_q | s2_v_q;

`ifdef COV_NEW_PULSE_EN
  logic             cov_new_q, cov_new_d;
  logic [TOT_W-1:0] cov_new_cnt_q, cov_new_cnt_d;

  always_comb begin
    cov_new_d     = s2_v_q && (total != '0) && !bus.clear;
    cov_new_cnt_d = cov_new_d ? total : '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cov_new_q     <= 1'b0;
      cov_new_cnt_q <= '0;
    end else begin
      cov_new_q     <= cov_new_d;
      cov_new_cnt_q <= cov_new_cnt_d;
    end
  end

  assign bus.cov_new     = cov_new_q;
  assign bus.cov_new_cnt = cov_new_cnt_q;
`endif
endmodule

// File: tb/tb_coverage_accumulator.sv
module tb_coverage_accumulator;
  localparam int NP = 1024;
  localparam int SP = 64;

  logic clock;
  logic reset;
  int   edge_cnt = 0;
  int   n_vec = 0;
  int   n_err = 0;

  coverage_accumulator_if #(.N_POINTS(NP), .SUM_W(30)) m_if ();
  coverage_accumulator_if #(.N_POINTS(SP), .SUM_W(4))  s_if ();

  coverage_accumulator #(.N_POINTS(NP), .GROUP(64), .SUM_W(30)) dut_m (
    .clock(clock), .reset(reset), .bus(m_if));
  coverage_accumulator #(.N_POINTS(SP), .GROUP(16), .SUM_W(4)) dut_s (
    .clock(clock), .reset(reset), .bus(s_if));

  always #5 clock = ~clock;
  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  // sig: 0 cov_sum, 1 busy, 2 saturated, 3 cov_new, 4 cov_new_cnt
  typedef struct {
    int          e;
    int          d;
    int          sig;
    logic [63:0] val;
    string       nm;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  function automatic logic [63:0] sample(input int d, input int sig);
    logic [63:0] r;
    r = '1;
    if (d == 0) begin
      case (sig)
        0: r = 64'(m_if.cov_sum);
        1: r = 64'(m_if.busy);
        2: r = 64'(m_if.saturated);
`ifdef COV_NEW_PULSE_EN
        3: r = 64'(m_if.cov_new);
        4: r = 64'(m_if.cov_new_cnt);
`endif
        default: r = '1;
      endcase
    end else begin
      case (sig)
        0: r = 64'(s_if.cov_sum);
        1: r = 64'(s_if.busy);
        2: r = 64'(s_if.saturated);
`ifdef COV_NEW_PULSE_EN
        3: r = 64'(s_if.cov_new);
        4: r = 64'(s_if.cov_new_cnt);
`endif
        default: r = '1;
      endcase
    end
    return r;
  endfunction

  task automatic expect_at(input int e, input int d, input int sig, input logic [63:0] v, input string nm);
    exp_t x;
    x.e = e; x.d = d; x.sig = sig; x.val = v; x.nm = nm;
    sb.push_back(x);
  endtask

  // Monitor: compares every scoreboard entry due after the current edge.
  always @(negedge clock) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].e == edge_cnt) begin
        check(sb[i].nm, sample(sb[i].d, sb[i].sig), sb[i].val);
        sb.delete(i);
      end
    end
  end

  task automatic drv(input logic v, input logic [NP-1:0] h, input logic c);
    m_if.hit_valid = v; m_if.hit = h; m_if.clear = c;
    @(posedge clock); #2;
  endtask

  task automatic drv_s(input logic v, input logic [SP-1:0] h, input logic c);
    s_if.hit_valid = v; s_if.hit = h; s_if.clear = c;
    @(posedge clock); #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(1'b0, '0, 1'b0);
  endtask

  function automatic logic [NP-1:0] oh(input int i);
    logic [NP-1:0] v;
    v = '0; v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [SP-1:0] oh_s(input int i);
    logic [SP-1:0] v;
    v = '0; v[i] = 1'b1;
    return v;
  endfunction

  initial begin
    int e;
    logic [NP-1:0] v10;
    clock = 1'b0; reset = 1'b1;
    m_if.clear = 1'b0; m_if.hit_valid = 1'b0; m_if.hit = '0;
    s_if.clear = 1'b0; s_if.hit_valid = 1'b0; s_if.hit = '0;
    repeat (3) @(posedge clock);
    #2; reset = 1'b0;

    // reset state
    e = edge_cnt;
    expect_at(e+1, 0, 0, 0, "rst_sum"); expect_at(e+1, 0, 1, 0, "rst_busy");
    expect_at(e+1, 0, 2, 0, "rst_sat"); expect_at(e+1, 1, 0, 0, "rst_sum_s");
    idle(3);

    // single point: latency 3, busy for two cycles
    e = edge_cnt;
    expect_at(e+1, 0, 0, 0, "t1_sum_e1"); expect_at(e+2, 0, 0, 0, "t1_sum_e2");
    expect_at(e+3, 0, 0, 1, "t1_sum_e3");
    expect_at(e+1, 0, 1, 1, "t1_busy_e1"); expect_at(e+2, 0, 1, 1, "t1_busy_e2");
    expect_at(e+3, 0, 1, 0, "t1_busy_e3");
`ifdef COV_NEW_PULSE_EN
    expect_at(e+2, 0, 3, 0, "t1_new_e2"); expect_at(e+3, 0, 3, 1, "t1_new_e3");
    expect_at(e+3, 0, 4, 1, "t1_cnt_e3"); expect_at(e+4, 0, 3, 0, "t1_new_e4");
`endif
    drv(1'b1, oh(5), 1'b0);
    idle(4);

    // repeated point contributes nothing; a fresh point adds one
    for (int k = 0; k < 4; k++) begin
      e = edge_cnt;
      expect_at(e+3, 0, 0, 1, "t2_rep_sum");
`ifdef COV_NEW_PULSE_EN
      expect_at(e+3, 0, 3, 0, "t2_rep_new");
`endif
      drv(1'b1, oh(5), 1'b0);
    end
    e = edge_cnt;
    expect_at(e+3, 0, 0, 2, "t2_sum");
`ifdef COV_NEW_PULSE_EN
    expect_at(e+3, 0, 3, 1, "t2_new"); expect_at(e+3, 0, 4, 1, "t2_cnt");
`endif
    drv(1'b1, oh(5) | oh(900), 1'b0);
    idle(4);

    // all points at once, then the same vector again
    e = edge_cnt;
    expect_at(e+2, 0, 0, 2, "t3_sum_pre"); expect_at(e+3, 0, 0, 1024, "t3_sum");
`ifdef COV_NEW_PULSE_EN
    expect_at(e+3, 0, 4, 1022, "t3_cnt");
`endif
    drv(1'b1, '1, 1'b0);
    e = edge_cnt;
    expect_at(e+3, 0, 0, 1024, "t3_sum_rep");
`ifdef COV_NEW_PULSE_EN
    expect_at(e+3, 0, 3, 0, "t3_new_rep");
`endif
    drv(1'b1, '1, 1'b0);
    idle(4);

    // clear, then clear while a vector is in flight
    e = edge_cnt;
    expect_at(e+1, 0, 0, 0, "t4_clr_sum"); expect_at(e+1, 0, 2, 0, "t4_clr_sat");
    expect_at(e+1, 0, 1, 0, "t4_clr_busy");
    drv(1'b0, '0, 1'b1);
    v10 = '0; v10[9:0] = '1;
    e = edge_cnt;
    expect_at(e+1, 0, 1, 1, "t4_busy_fl"); expect_at(e+2, 0, 1, 0, "t4_busy_drop");
    expect_at(e+2, 0, 0, 0, "t4_sum_e2"); expect_at(e+3, 0, 0, 0, "t4_sum_e3");
    expect_at(e+4, 0, 0, 0, "t4_sum_e4");
    drv(1'b1, v10, 1'b0);
    drv(1'b0, '0, 1'b1);
    idle(3);
    e = edge_cnt;
    expect_at(e+3, 0, 0, 1, "t4_bit0");
    drv(1'b1, oh(0), 1'b0);
    idle(3);
    // clear dominates hit_valid on the same cycle
    e = edge_cnt;
    expect_at(e+1, 0, 0, 0, "t4_dom_sum"); expect_at(e+1, 0, 1, 0, "t4_dom_busy");
    expect_at(e+3, 0, 0, 0, "t4_dom_sum3");
    drv(1'b1, oh(3), 1'b1);
    idle(3);
    e = edge_cnt;
    expect_at(e+3, 0, 0, 1, "t4_bit3");
    drv(1'b1, oh(3), 1'b0);
    idle(3);

    // asynchronous reset with three vectors in flight
    drv(1'b0, '0, 1'b1);
    idle(2);
    drv(1'b1, oh(100), 1'b0);
    drv(1'b1, oh(101), 1'b0);
    drv(1'b1, oh(102), 1'b0);
    m_if.hit_valid = 1'b0; m_if.hit = '0;
    #1;
    check("t5_pre_sum", 64'(m_if.cov_sum), 1);
    check("t5_pre_busy", 64'(m_if.busy), 1);
    reset = 1'b1;
    #1;
    check("t5_rst_sum", 64'(m_if.cov_sum), 0);
    check("t5_rst_busy", 64'(m_if.busy), 0);
    check("t5_rst_sat", 64'(m_if.saturated), 0);
`ifdef COV_NEW_PULSE_EN
    check("t5_rst_new", 64'(m_if.cov_new), 0);
`endif
    #4; reset = 1'b0;
    e = edge_cnt;
    expect_at(e+2, 0, 0, 0, "t5_post_e2"); expect_at(e+3, 0, 0, 1, "t5_bit7");
    drv(1'b1, oh(7), 1'b0);
    idle(3);
    e = edge_cnt;
    expect_at(e+3, 0, 0, 2, "t5_bit100");
    drv(1'b1, oh(100), 1'b0);
    idle(3);

    // saturation on the 4-bit instance
    for (int k = 0; k < 20; k++) begin
      e = edge_cnt;
      expect_at(e+3, 1, 0, (k + 1 > 15) ? 15 : k + 1, "sat_sum");
      expect_at(e+3, 1, 2, (k + 1 >= 15) ? 1 : 0, "sat_flag");
      drv_s(1'b1, oh_s(k), 1'b0);
    end
    s_if.hit_valid = 1'b0; s_if.hit = '0;
    idle(3);
    e = edge_cnt;
    expect_at(e+1, 1, 0, 15, "sat_hold"); expect_at(e+1, 1, 2, 1, "sat_hold_flag");
    expect_at(e+1, 1, 1, 0, "sat_busy");
    idle(1);
    e = edge_cnt;
    expect_at(e+1, 1, 0, 0, "sat_clr_sum"); expect_at(e+1, 1, 2, 0, "sat_clr_flag");
    drv_s(1'b0, '0, 1'b1);
    e = edge_cnt;
    expect_at(e+2, 1, 0, 0, "sat_wide_pre"); expect_at(e+3, 1, 0, 15, "sat_wide_sum");
    expect_at(e+3, 1, 2, 1, "sat_wide_flag");
`ifdef COV_NEW_PULSE_EN
    expect_at(e+3, 1, 4, 64, "sat_wide_cnt");
`endif
    drv_s(1'b1, '1, 1'b0);
    drv_s(1'b0, '0, 1'b0);
    idle(4);

    check("sb_drain", 64'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/coverage_accumulator.md
Name: coverage_accumulator

Overview:
- Upstream producer of the 30-bit coverage sum that the fuzzing coverage monitor and DPI coverage collector sample each round.
- Keeps a bitmap of coverage points seen since the last clear and adds newly set points to a saturating running total.
- Pipelined popcount so the block closes timing inside the SoC at N_POINTS up to 4096.

Parameters:
N_POINTS, 1024, number of coverage points in the hit vector (multiple of GROUP)
GROUP, 64, points per partial-popcount group in stage 2
SUM_W, 30, width of cov_sum

Ports:
clock  input  1  core clock
reset  input  1  asynchronous, active-high reset
clear  input  1  synchronous round restart (meta reset); clears bitmap, pipeline and sum
hit_valid  input  1  hit vector valid this cycle
hit  input  N_POINTS  coverage points hit this cycle
cov_sum  output  SUM_W  count of distinct points hit since last clear/reset
busy  output  1  high while any pipeline stage holds valid data
saturated  output  1  cov_sum has reached 2^SUM_W-1

Behaviour:
- Reset (async, active-high): seen bitmap, all stage valids/data, cov_sum, saturated all 0; busy 0.
- S1 (edge t+1): s1_v <= hit_valid & ~clear; s1_hit <= hit_valid ? hit : 0.
- S2 (edge t+2): new = s1_hit & ~seen; seen <= seen | s1_hit (when s1_v); per-group popcount of new registered into N_POINTS/GROUP counters of width clog2(GROUP)+1; s2_v <= s1_v.
- S3 (edge t+3): total = sum of group counts; cov_sum <= min(cov_sum + total, 2^SUM_W-1) when s2_v; saturated <= 1 when the result equals the maximum.
- Latency: hit presented on cycle t is reflected in cov_sum after edge t+3. Throughput: one vector per cycle, no backpressure.
- Same point hit in consecutive cycles: second occurrence sees updated seen and contributes 0 (seen updated the same edge new is computed).
- Same point in the same vector counts once (bitmap OR, no duplicates possible).
- hit_valid=0: no stage advances valid data; seen, cov_sum unchanged.
- clear: at the next edge, seen, s1/s2 valid and data, cov_sum, saturated <= 0. Hits in flight are discarded. clear dominates hit_valid on the same cycle, and that vector is dropped.
- Saturation: cov_sum never wraps; once saturated, further new points are still marked in seen but the sum holds.
- busy = s1_v | s2_v (combinational from registers).
- Reset asserted mid-operation: everything returns to reset values immediately; first valid vector after reset release behaves as on an empty bitmap.
- Summation width: internal adder at least SUM_W+1 bits, so the saturation compare is exact.

Optional Feature:
- Macro: COV_NEW_PULSE_EN
- With it defined, adds output cov_new (1 bit) and cov_new_cnt (clog2(N_POINTS)+1 bits).
  - cov_new pulses for exactly one cycle, aligned with the S3 update, when total != 0.
  - cov_new_cnt carries total on that cycle and is 0 otherwise.
  - Both outputs reset to 0 and are cleared by clear.
- Without it, the ports and logic are absent; all other behaviour is identical.

Test Plan:
- After reset, hit_valid=1 with hit bit 5 only at cycle 10 -> cov_sum 0 through cycle 12, 1 after edge 13; busy high for cycles 11-12.
- Bit 5 driven in 4 consecutive cycles, then bit 5|bit 900 -> cov_sum ends at 2; with COV_NEW_PULSE_EN, exactly two cov_new pulses, each with cov_new_cnt=1.
- Single cycle with all N_POINTS bits set -> cov_sum=1024 three edges later; repeating the vector leaves it at 1024.
- Bits 0-9 at cycle t, clear at t+1 -> cov_sum stays 0 and busy drops. Then bit 0 -> cov_sum=1, proving the bitmap was cleared.
- SUM_W=4, 20 distinct points over 20 cycles -> cov_sum caps at 15, saturated=1, no wrap; clear returns both to 0.
- Assert reset asynchronously between edges while 3 vectors are in flight -> outputs go to 0 immediately, not waiting for a clock edge; the first post-reset vector with bit 7 gives cov_sum=1.
